// File: rtl/pipe_pkg.sv
// Shared types for the LEGv8 pipeline hazard/forwarding control:
// forwarding-select encoding and the per-stage destination shadow entry.
package pipe_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned ZERO_REG = 31;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EX  = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } stage_info_t;

endpackage

// File: rtl/fwd_src_sel.sv
// Forwarding select for one source register against the EX and MEM shadow
// entries; also flags a load in EX that this source depends on.
module fwd_src_sel #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic [REG_W-1:0]     src,
  input  logic                 used,
  input  pipe_pkg::stage_info_t ex_e,
  input  pipe_pkg::stage_info_t mem_e,
  output pipe_pkg::fwd_sel_t   sel,
  output logic                 load_hit
);
  import pipe_pkg::*;

  logic ex_live;
  logic mem_live;
  logic unused_mem_memread;

  // XZR is never a producer, so a zero-register source never matches.
  assign ex_live  = used && (src != REG_W'(ZERO_REG)) && ex_e.valid
                    && ex_e.regwrite && (ex_e.rd == src);
  assign mem_live = used && (src != REG_W'(ZERO_REG)) && mem_e.valid
                    && mem_e.regwrite && (mem_e.rd == src);

  assign load_hit           = ex_live && ex_e.memread;
  assign unused_mem_memread = mem_e.memread;

  always_comb begin
    sel = FWD_REG;
    if (ex_live && !ex_e.memread) begin
      sel = FWD_EX;
    end else if (mem_live) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// LEGv8 hazard controller: load-use stall detection in ID and registered
// forwarding selects that line up with the instruction once it is in EX.
module hazard_forward_ctrl #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic             ex_bubble,
  output logic [1:0]       rnSRC,
  output logic [1:0]       rmSRC,
  output logic [CNT_W-1:0] stall_count
);
  import pipe_pkg::*;

  stage_info_t ex_q;
  stage_info_t mem_q;
  stage_info_t id_e;
  fwd_sel_t    rn_sel;
  fwd_sel_t    rm_sel;
  fwd_sel_t    rn_q;
  fwd_sel_t    rm_q;
  logic        rn_hit;
  logic        rm_hit;
  logic        issue;
  logic [CNT_W-1:0] cnt_q;

  fwd_src_sel #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_rn_sel (
    .src      (id_rn),
    .used     (id_uses_rn),
    .ex_e     (ex_q),
    .mem_e    (mem_q),
    .sel      (rn_sel),
    .load_hit (rn_hit)
  );

  fwd_src_sel #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_rm_sel (
    .src      (id_rm),
    .used     (id_uses_rm),
    .ex_e     (ex_q),
    .mem_e    (mem_q),
    .sel      (rm_sel),
    .load_hit (rm_hit)
  );

  // Flush outranks the load-use stall; reset low masks it entirely.
  assign stall = reset && id_valid && !flush && (rn_hit || rm_hit);
  assign issue = id_valid && !stall && !flush;

  always_comb begin
    id_e          = '0;
    id_e.valid    = issue;
    id_e.rd       = id_rd;
    id_e.regwrite = id_regwrite;
    id_e.memread  = id_memread;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      rn_q      <= FWD_REG;
      rm_q      <= FWD_REG;
      ex_bubble <= 1'b0;
      cnt_q     <= '0;
    end else begin
      mem_q     <= ex_q;
      ex_q      <= id_e;
      rn_q      <= issue ? rn_sel : FWD_REG;
      rm_q      <= issue ? rm_sel : FWD_REG;
      ex_bubble <= stall || flush;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign rnSRC       = rn_q;
  assign rmSRC       = rm_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Randomized bench for hazard_forward_ctrl against an instruction-history model.
module tb_hazard_forward_ctrl;

  localparam int unsigned CW = 3;

  typedef struct {
    bit       v;
    bit [4:0] rn;
    bit [4:0] rm;
    bit       urn;
    bit       urm;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } ins_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_uses_rn, id_uses_rm, id_regwrite, id_memread, flush;
  logic [4:0]    id_rn, id_rm, id_rd;
  logic          stall, ex_bubble;
  logic [1:0]    rnSRC, rmSRC;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  // Model: the two most recent instructions that entered EX (index 0 = youngest).
  ins_t hist[2];
  int   exp_rn = 0, exp_rm = 0, exp_bub = 0, exp_cnt = 0;
  bit   primed = 0;

  hazard_forward_ctrl #(.REG_W(5), .ZERO_REG(31), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_uses_rn (id_uses_rn),
    .id_uses_rm (id_uses_rm),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .flush      (flush),
    .stall      (stall),
    .ex_bubble  (ex_bubble),
    .rnSRC      (rnSRC),
    .rmSRC      (rmSRC),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input ins_t p, input bit [4:0] r);
    return p.v && p.rw && (p.rd == r) && (r != 5'd31);
  endfunction

  function automatic int want_sel(input bit used, input bit [4:0] r);
    if (!used) return 0;
    if (writes(hist[0], r)) return 1;
    if (writes(hist[1], r)) return 2;
    return 0;
  endfunction

  function automatic ins_t mk(input bit v, input bit [4:0] rn, input bit urn,
                              input bit [4:0] rm, input bit urm,
                              input bit [4:0] rd, input bit rw, input bit mr);
    ins_t i;
    i.v = v; i.rn = rn; i.urn = urn; i.rm = rm; i.urm = urm;
    i.rd = rd; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  // One pipeline cycle: check last edge's outputs, drive ID, check stall, advance model.
  task automatic step(input ins_t i, input bit fl, input bit rst_n);
    bit exp_stall;
    bit enters;
    if (primed) begin
      check("rnSRC", int'(rnSRC), exp_rn);
      check("rmSRC", int'(rmSRC), exp_rm);
      check("ex_bubble", int'(ex_bubble), exp_bub);
      check("stall_count", int'(stall_count), exp_cnt);
    end
    reset = rst_n; id_valid = i.v; id_rn = i.rn; id_rm = i.rm;
    id_uses_rn = i.urn; id_uses_rm = i.urm; id_rd = i.rd;
    id_regwrite = i.rw; id_memread = i.mr; flush = fl;
    #1;
    exp_stall = rst_n && i.v && !fl && hist[0].mr &&
                ((i.urn && writes(hist[0], i.rn)) || (i.urm && writes(hist[0], i.rm)));
    check("stall", int'(stall), int'(exp_stall));
    if (!rst_n) begin
      hist[0].v = 0; hist[1].v = 0;
      exp_rn = 0; exp_rm = 0; exp_bub = 0; exp_cnt = 0;
    end else begin
      enters  = i.v && !exp_stall && !fl;
      exp_rn  = enters ? want_sel(i.urn, i.rn) : 0;
      exp_rm  = enters ? want_sel(i.urm, i.rm) : 0;
      exp_bub = (exp_stall || fl) ? 1 : 0;
      if (exp_stall && exp_cnt < (1 << CW) - 1) exp_cnt++;
      hist[1] = hist[0];
      hist[0] = i;
      hist[0].v = enters;
    end
    primed = 1;
    @(negedge clk);
  endtask

  function automatic bit [4:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(1, 4));
  endfunction

  ins_t nop, cur;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    hist[0] = nop; hist[1] = nop;
    @(negedge clk);
    step(nop, 0, 0);
    step(nop, 0, 0);
    check("reset_stall", int'(stall), 0);

    // ADD X1 ; SUB rn=1 rm=2 -> rnSRC=01
    step(mk(1, 2, 1, 3, 1, 1, 1, 0), 0, 1);
    step(mk(1, 1, 1, 2, 1, 4, 1, 0), 0, 1);
    step(nop, 0, 1);
    // ADD X3 ; unrelated ; ORR rm=3 -> rmSRC=10
    step(mk(1, 0, 1, 0, 1, 3, 1, 0), 0, 1);
    step(mk(1, 5, 1, 6, 1, 8, 1, 0), 0, 1);
    step(mk(1, 9, 1, 3, 1, 10, 1, 0), 0, 1);
    // LDUR X5 ; ADD rn=5 (stalls once, then forwards from WB)
    step(mk(1, 1, 1, 0, 0, 5, 1, 1), 0, 1);
    step(mk(1, 5, 1, 0, 0, 6, 1, 0), 0, 1);
    step(mk(1, 5, 1, 0, 0, 6, 1, 0), 0, 1);
    // ADD X7 ; ADD X7 ; consumer rn=7 -> younger producer wins
    step(mk(1, 0, 1, 0, 0, 7, 1, 0), 0, 1);
    step(mk(1, 0, 1, 0, 0, 7, 1, 0), 0, 1);
    step(mk(1, 7, 1, 0, 0, 9, 1, 0), 0, 1);
    // LDUR X31 ; consumer rn=31 -> no stall
    step(mk(1, 1, 1, 0, 0, 31, 1, 1), 0, 1);
    step(mk(1, 31, 1, 0, 0, 2, 1, 0), 0, 1);
    // Flush on a load-use cycle
    step(mk(1, 1, 1, 0, 0, 4, 1, 1), 0, 1);
    step(mk(1, 4, 1, 0, 0, 2, 1, 0), 1, 1);
    // Enough load-use pairs to saturate the 3-bit counter
    for (int k = 0; k < 10; k++) begin
      step(mk(1, 0, 0, 0, 0, 2, 1, 1), 0, 1);
      step(mk(1, 0, 0, 2, 1, 3, 1, 0), 0, 1);
      step(mk(1, 0, 0, 2, 1, 3, 1, 0), 0, 1);
    end
    step(nop, 0, 1);
    check("sat_count", int'(stall_count), (1 << CW) - 1);
    // Reset asserted during a stall
    step(mk(1, 0, 0, 0, 0, 2, 1, 1), 0, 1);
    step(mk(1, 2, 1, 0, 0, 3, 1, 0), 0, 0);
    step(mk(1, 2, 1, 0, 0, 3, 1, 0), 0, 1);

    for (int n = 0; n < 3000; n++) begin
      cur.v   = ($urandom_range(0, 9) != 0);
      cur.rn  = rreg(); cur.rm = rreg(); cur.rd = rreg();
      cur.urn = ($urandom_range(0, 4) != 0);
      cur.urm = ($urandom_range(0, 2) != 0);
      cur.rw  = ($urandom_range(0, 4) != 0);
      cur.mr  = ($urandom_range(0, 2) == 0);
      step(cur, ($urandom_range(0, 9) == 0), ($urandom_range(0, 63) != 0));
    end
    step(nop, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
